// File: rtl/svc_rv_soc_run_ctrl_pkg.sv
// Shared types and sizing helpers for the RISC-V SoC run/halt sequencer.
package svc_rv_soc_run_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int unsigned RST_CYCLES_DEFAULT = 4;
   localparam int unsigned HOLD_CNT_W         = $clog2(RST_CYCLES_DEFAULT + 1);

   // Hold-counter width for an arbitrary reset length, never narrower than 1 bit.
   function automatic int unsigned hold_cnt_w(input int unsigned rst_cycles);
      return (rst_cycles < 1) ? 1 : $clog2(rst_cycles + 1);
   endfunction

endpackage

// File: rtl/svc_rv_run_hold_cnt.sv
// Down-counter that times the core reset hold; expired_o is high once it reaches zero.
module svc_rv_run_hold_cnt
   import svc_rv_soc_run_ctrl_pkg::*;
#(
   parameter int unsigned W        = HOLD_CNT_W,
   parameter int unsigned LOAD_VAL = RST_CYCLES_DEFAULT - 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [W-1:0] LOAD_V = W'(LOAD_VAL);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_V;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/svc_rv_soc_run_ctrl.sv
// Run/halt sequencer: holds the SoC core in reset, runs it, and stops on ebreak, trap or watchdog.
module svc_rv_soc_run_ctrl
   import svc_rv_soc_run_ctrl_pkg::*;
#(
   parameter int unsigned     CNT_W        = 32,
   parameter int unsigned     RST_CYCLES   = RST_CYCLES_DEFAULT,
   parameter logic [CNT_W-1:0] TIMEOUT     = '0,
   parameter bit              AUTO_RESTART = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             core_ebreak,
   input  logic             core_trap,
   output logic             core_rst_n,
   output logic             busy,
   output logic             done,
   output logic             trapped,
   output logic             timed_out,
   output logic [CNT_W-1:0] cycles,
   output logic [CNT_W-1:0] run_count,
   output state_t           dbg_state
);

   localparam int unsigned     HOLD_W     = hold_cnt_w(RST_CYCLES);
   localparam logic [CNT_W-1:0] TIMEOUT_M1 = TIMEOUT - 1'b1;

   state_t            state_q, state_d;
   logic              core_rst_n_q, core_rst_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              trapped_q, trapped_d;
   logic              timed_out_q, timed_out_d;
   logic [CNT_W-1:0]  cycles_q, cycles_d;
   logic [CNT_W-1:0]  run_count_q, run_count_d;
   logic              hold_load;
   logic              hold_expired;

   svc_rv_run_hold_cnt #(
      .W        (HOLD_W),
      .LOAD_VAL (RST_CYCLES - 1)
   ) u_hold_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (hold_load),
      .en_i      (state_q == HOLD),
      .expired_o (hold_expired)
   );

   always_comb begin
      state_d     = state_q;
      trapped_d   = trapped_q;
      timed_out_d = timed_out_q;
      cycles_d    = cycles_q;
      run_count_d = run_count_q;

      case (state_q)
         IDLE: begin
            if (!abort && start) begin
               state_d     = HOLD;
               cycles_d    = '0;
               trapped_d   = 1'b0;
               timed_out_d = 1'b0;
            end
         end
         HOLD: begin
            if (abort) begin
               state_d = IDLE;
            end else if (hold_expired) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Every RUN cycle counts, including the one that ends the run.
            if (cycles_q != '1) begin
               cycles_d = cycles_q + 1'b1;
            end
            if (abort) begin
               state_d = IDLE;
            end else if (core_trap) begin
               state_d   = DONE;
               trapped_d = 1'b1;
            end else if (core_ebreak) begin
               state_d     = DONE;
               run_count_d = run_count_q + 1'b1;
            end else if ((TIMEOUT != '0) && (cycles_q == TIMEOUT_M1)) begin
               state_d     = DONE;
               timed_out_d = 1'b1;
            end
         end
         DONE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (start || (AUTO_RESTART && !trapped_q && !timed_out_q)) begin
               state_d     = HOLD;
               cycles_d    = '0;
               trapped_d   = 1'b0;
               timed_out_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      hold_load    = (state_d == HOLD) && (state_q != HOLD);
      core_rst_n_d = (state_d == RUN);
      busy_d       = (state_d == HOLD) || (state_d == RUN);
      done_d       = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         core_rst_n_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         trapped_q    <= 1'b0;
         timed_out_q  <= 1'b0;
         cycles_q     <= '0;
         run_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         core_rst_n_q <= core_rst_n_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         trapped_q    <= trapped_d;
         timed_out_q  <= timed_out_d;
         cycles_q     <= cycles_d;
         run_count_q  <= run_count_d;
      end
   end

   assign core_rst_n = core_rst_n_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign trapped    = trapped_q;
   assign timed_out  = timed_out_q;
   assign cycles     = cycles_q;
   assign run_count  = run_count_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_svc_rv_soc_run_ctrl.sv
// Bench for the run/halt sequencer: vector table, hand sequences, and an auto-restart instance.
module tb_svc_rv_soc_run_ctrl;
   import svc_rv_soc_run_ctrl_pkg::*;

   localparam int EW = 69;

   typedef struct {
      logic          start;
      logic          abort;
      logic          ebreak;
      logic          trap;
      logic [EW-1:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, abort, core_ebreak, core_trap;
   logic        core_rst_n, busy, done, trapped, timed_out;
   logic [31:0] cycles, run_count;
   state_t      dbg_state;

   logic        ar_start, ar_abort, ar_ebreak, ar_trap;
   logic        ar_core_rst_n, ar_busy, ar_done, ar_trapped, ar_timed_out;
   logic [31:0] ar_cycles, ar_run_count;
   state_t      ar_dbg_state;

   logic [EW-1:0] exp_q[$];
   logic [31:0]   ar_q[$];
   int            checks = 0;
   int            errors = 0;
   vec_t          tbl[18];

   always #5 clk = ~clk;

   svc_rv_soc_run_ctrl #(
      .CNT_W(32), .RST_CYCLES(4), .TIMEOUT(32'd20), .AUTO_RESTART(1'b0)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .core_ebreak(core_ebreak), .core_trap(core_trap),
      .core_rst_n(core_rst_n), .busy(busy), .done(done), .trapped(trapped),
      .timed_out(timed_out), .cycles(cycles), .run_count(run_count),
      .dbg_state(dbg_state)
   );

   svc_rv_soc_run_ctrl #(
      .CNT_W(32), .RST_CYCLES(4), .TIMEOUT(32'd0), .AUTO_RESTART(1'b1)
   ) u_dut_ar (
      .clk(clk), .rst_n(rst_n), .start(ar_start), .abort(ar_abort),
      .core_ebreak(ar_ebreak), .core_trap(ar_trap),
      .core_rst_n(ar_core_rst_n), .busy(ar_busy), .done(ar_done), .trapped(ar_trapped),
      .timed_out(ar_timed_out), .cycles(ar_cycles), .run_count(ar_run_count),
      .dbg_state(ar_dbg_state)
   );

   function automatic logic [EW-1:0] pk(input logic crn, input logic b, input logic d,
                                        input logic tr, input logic to,
                                        input logic [31:0] cyc, input logic [31:0] rc);
      return {crn, b, d, tr, to, cyc, rc};
   endfunction

   function automatic vec_t mk(input logic s, input logic a, input logic e, input logic t,
                               input logic [EW-1:0] x);
      vec_t v;
      v.start = s; v.abort = a; v.ebreak = e; v.trap = t; v.exp = x;
      return v;
   endfunction

   task automatic check(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // One clock: drive inputs, queue the expectation, compare just after the edge.
   task automatic step(input logic s, input logic a, input logic e, input logic t,
                       input logic [EW-1:0] x, input string nm);
      logic [EW-1:0] want;
      start = s; abort = a; core_ebreak = e; core_trap = t;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      check(nm, {core_rst_n, busy, done, trapped, timed_out, cycles, run_count}, want);
   endtask

   task automatic do_start_hold(input logic [31:0] rc, input string nm);
      step(1, 0, 0, 0, pk(0, 1, 0, 0, 0, 0, rc), {nm, "_start"});
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, pk(0, 1, 0, 0, 0, 0, rc), {nm, "_hold"});
      step(0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, rc), {nm, "_run0"});
   endtask

   initial begin
      logic       prev_done;
      logic [31:0] want_rc;
      rst_n = 1'b0;
      start = 0; abort = 0; core_ebreak = 0; core_trap = 0;
      ar_start = 0; ar_abort = 0; ar_ebreak = 0; ar_trap = 0;

      tbl[0] = mk(0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
      tbl[1] = mk(1, 0, 0, 0, pk(0, 1, 0, 0, 0, 0, 0));
      tbl[2] = mk(0, 0, 0, 0, pk(0, 1, 0, 0, 0, 0, 0));
      tbl[3] = mk(0, 0, 1, 0, pk(0, 1, 0, 0, 0, 0, 0));
      tbl[4] = mk(0, 0, 0, 1, pk(0, 1, 0, 0, 0, 0, 0));
      for (int i = 5; i < 15; i++) tbl[i] = mk(i == 8, 0, 0, 0, pk(1, 1, 0, 0, 0, 32'(i - 5), 0));
      tbl[15] = mk(0, 0, 1, 0, pk(0, 0, 1, 0, 0, 10, 1));
      tbl[16] = mk(0, 0, 0, 0, pk(0, 0, 1, 0, 0, 10, 1));
      tbl[17] = mk(0, 0, 0, 1, pk(0, 0, 1, 0, 0, 10, 1));

      #12;
      check("reset_outputs", {core_rst_n, busy, done, trapped, timed_out, cycles, run_count}, '0);
      check("reset_state", EW'(dbg_state), EW'(IDLE));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 18; i++) step(tbl[i].start, tbl[i].abort, tbl[i].ebreak, tbl[i].trap,
                                         tbl[i].exp, $sformatf("tbl_%0d", i));

      do_start_hold(1, "prio");
      step(0, 0, 0, 0, pk(1, 1, 0, 0, 0, 1, 1), "prio_run1");
      step(0, 0, 0, 0, pk(1, 1, 0, 0, 0, 2, 1), "prio_run2");
      step(0, 0, 1, 1, pk(0, 0, 1, 1, 0, 3, 1), "prio_trap_over_ebreak");

      do_start_hold(1, "wdog");
      for (int i = 1; i < 20; i++) step(0, 0, 0, 0, pk(1, 1, 0, 0, 0, 32'(i), 1), "wdog_run");
      step(0, 0, 0, 0, pk(0, 0, 1, 0, 1, 20, 1), "wdog_expire");

      step(0, 1, 0, 0, pk(0, 0, 0, 0, 1, 20, 1), "abort_from_done");
      step(1, 1, 0, 0, pk(0, 0, 0, 0, 1, 20, 1), "abort_beats_start_idle");

      step(1, 0, 0, 0, pk(0, 1, 0, 0, 0, 0, 1), "hold_abort_start");
      step(0, 0, 0, 0, pk(0, 1, 0, 0, 0, 0, 1), "hold_abort_hold");
      step(0, 1, 0, 0, pk(0, 0, 0, 0, 0, 0, 1), "hold_abort");

      do_start_hold(1, "run_abort");
      for (int i = 1; i < 5; i++) step(0, 0, 0, 0, pk(1, 1, 0, 0, 0, 32'(i), 1), "run_abort_run");
      step(1, 1, 0, 0, pk(0, 0, 0, 0, 0, 5, 1), "run_abort");
      step(0, 0, 0, 0, pk(0, 0, 0, 0, 0, 5, 1), "run_abort_stay_idle");

      do_start_hold(1, "arst");
      for (int i = 1; i < 4; i++) step(0, 0, 0, 0, pk(1, 1, 0, 0, 0, 32'(i), 1), "arst_run");
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_async_clear", {core_rst_n, busy, done, trapped, timed_out, cycles, run_count}, '0);
      @(posedge clk);
      #1;
      check("arst_held", {core_rst_n, busy, done, trapped, timed_out, cycles, run_count}, '0);
      rst_n = 1'b1;
      do_start_hold(0, "post_rst");
      step(0, 0, 0, 0, pk(1, 1, 0, 0, 0, 1, 0), "post_rst_run1");
      step(0, 0, 1, 0, pk(0, 0, 1, 0, 0, 2, 1), "post_rst_ebreak");

      // Auto-restart: ebreak held high ends every run on its first RUN cycle.
      ar_q.push_back(32'd1);
      ar_q.push_back(32'd2);
      ar_q.push_back(32'd3);
      ar_start = 1'b1;
      ar_ebreak = 1'b1;
      @(posedge clk);
      #1;
      ar_start = 1'b0;
      prev_done = 1'b0;
      for (int c = 0; c < 200 && ar_q.size() != 0; c++) begin
         @(posedge clk);
         #1;
         if (ar_done && !prev_done) begin
            want_rc = ar_q.pop_front();
            check("ar_run_count", EW'(ar_run_count), EW'(want_rc));
            check("ar_cycles", EW'(ar_cycles), EW'(1));
         end
         prev_done = ar_done;
      end
      check("ar_all_runs_seen", EW'(ar_q.size()), '0);
      ar_ebreak = 1'b0;
      @(posedge clk);
      #1;
      check("ar_restart_hold", EW'({ar_busy, ar_done, ar_core_rst_n}), EW'(3'b100));
      ar_abort = 1'b1;
      @(posedge clk);
      #1;
      ar_abort = 1'b0;
      check("ar_abort", EW'({ar_busy, ar_done, ar_run_count}), EW'({2'b00, 32'd3}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
